// File: rtl/mem_read_arbiter.sv
// rtl/mem_read_arbiter.sv - two-requester round-robin read arbiter with burst lock for a single-port RAM
// Grants are combinational; a tag shift register returns per-requester rvalid RD_LAT cycles later.
module mem_read_arbiter #(
   parameter int AW        = 8,
   parameter int DW        = 16,
   parameter int RD_LAT    = 1,
   parameter int MAX_BURST = 64
) (
   input  logic          mclk,
   input  logic          reset,
   input  logic          req0,
   input  logic [AW-1:0] addr0,
   input  logic          last0,
   output logic          gnt0,
   output logic          rvalid0,
   input  logic          req1,
   input  logic [AW-1:0] addr1,
   input  logic          last1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic          mem_ena,
   output logic [AW-1:0] mem_addra,
   input  logic [DW-1:0] mem_douta,
   output logic [DW-1:0] rdata,
   output logic [1:0]    owner
);

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] OWN0 = 2'b01;
   localparam logic [1:0] OWN1 = 2'b10;

   localparam int CW = $clog2(MAX_BURST + 2);
   localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   logic [1:0]        state_q, state_d;
   logic              last_winner_q, last_winner_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CW-1:0]     beat_n;
   logic [RD_LAT-1:0] tag_v_q, tag_v_d;
   logic [RD_LAT-1:0] tag_id_q, tag_id_d;

   logic              sel_v;
   logic              sel_id;
   logic [AW-1:0]     sel_addr;
   logic              sel_last;
   logic              own_id;
   logic              issue;

   assign own_id = (state_q == OWN1);
   assign beat_n = cnt_q + CNT_ONE;

   always_comb begin
      state_d       = state_q;
      last_winner_d = last_winner_q;
      cnt_d         = cnt_q;
      sel_v         = 1'b0;
      sel_id        = 1'b0;
      sel_addr      = '0;
      sel_last      = 1'b0;
      case (state_q)
         IDLE: begin
            // last_winner_q=1 means requester 1 won most recently, so 0 is favoured on a tie.
            if (req0 && (!req1 || last_winner_q)) begin
               sel_v    = 1'b1;
               sel_id   = 1'b0;
               sel_addr = addr0;
               sel_last = last0;
            end else if (req1) begin
               sel_v    = 1'b1;
               sel_id   = 1'b1;
               sel_addr = addr1;
               sel_last = last1;
            end
            if (sel_v) begin
               if (sel_last || (MAX_BURST == 1)) begin
                  last_winner_d = sel_id;
               end else begin
                  state_d = sel_id ? OWN1 : OWN0;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         OWN0, OWN1: begin
            sel_id   = own_id;
            sel_v    = own_id ? req1 : req0;
            sel_addr = own_id ? addr1 : addr0;
            sel_last = own_id ? last1 : last0;
            // Bubble cycles (owner not requesting) leave the counter untouched.
            if (sel_v) begin
               if (sel_last || ((MAX_BURST != 0) && (beat_n == BURST_MAX))) begin
                  state_d       = IDLE;
                  last_winner_d = own_id;
                  cnt_d         = '0;
               end else begin
                  cnt_d = beat_n;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign issue     = sel_v & ~reset;
   assign gnt0      = issue & ~sel_id;
   assign gnt1      = issue & sel_id;
   assign mem_ena   = issue;
   assign mem_addra = issue ? sel_addr : '0;
   assign owner     = state_q;
   assign rdata     = mem_douta;

   assign tag_v_d  = RD_LAT'({tag_v_q, issue});
   assign tag_id_d = RD_LAT'({tag_id_q, sel_id});

   assign rvalid0 = tag_v_q[RD_LAT-1] & ~tag_id_q[RD_LAT-1];
   assign rvalid1 = tag_v_q[RD_LAT-1] & tag_id_q[RD_LAT-1];

   always_ff @(posedge mclk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         last_winner_q <= 1'b1;
         cnt_q         <= '0;
         tag_v_q       <= '0;
         tag_id_q      <= '0;
      end else begin
         state_q       <= state_d;
         last_winner_q <= last_winner_d;
         cnt_q         <= cnt_d;
         tag_v_q       <= tag_v_d;
         tag_id_q      <= tag_id_d;
      end
   end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares the single-port block RAM (8-bit address, 16-bit data, registered read) between two read requesters, e.g. the find-max datapath and a second scan engine or host loader.
- Round-robin arbitration with burst locking, so a requester keeps the memory for a whole address sweep.
- Tags each issued read and returns a per-requester data-valid strobe aligned to the RAM read latency.
- Sits between the requesting datapaths and the blk_mem_gen_0 instance, inside TOP.

Parameters:
- AW, 8, address width (matches addra).
- DW, 16, data width (matches douta).
- RD_LAT, 1, RAM read latency in cycles (1 to 4).
- MAX_BURST, 64, maximum beats per ownership before forced release; 0 disables the guard.

Ports:
- mclk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  requester 0 has a valid read address this cycle.
- addr0  in  AW  requester 0 read address.
- last0  in  1  requester 0's current beat is the final one of its burst.
- gnt0  out  1  requester 0 beat accepted this cycle (combinational).
- rvalid0  out  1  mem_douta holds requester 0 data this cycle.
- req1, addr1, last1, gnt1, rvalid1  same as requester 0, for requester 1.
- mem_ena  out  1  RAM enable.
- mem_addra  out  AW  RAM address.
- mem_douta  in  DW  RAM read data.
- rdata  out  DW  equals mem_douta; valid only when rvalid0 or rvalid1 is high.
- owner  out  2  00 idle, 01 requester 0 locked, 10 requester 1 locked.

Behaviour:
- Reset (asynchronous, immediate):
  - state IDLE; last_winner=1, so requester 0 has priority first.
  - beat counter 0; tag pipeline cleared.
  - gnt*=0, rvalid*=0, mem_ena=0, mem_addra=0, owner=00.
- States are IDLE, OWN0, OWN1. owner reflects the state.
- IDLE:
  - With one request, that requester is selected.
  - With both requesting, the requester that is not last_winner is selected.
  - The selected requester gets gnt=1 in the same cycle; mem_ena=1 and mem_addra=its addr.
  - If last=1, or MAX_BURST=1: stay in IDLE and set last_winner to the selected requester.
  - Otherwise go to OWNx and set beat counter to 1.
- OWNx:
  - gnt_x = req_x; the other requester's gnt is held at 0.
  - mem_ena=req_x; mem_addra=addr_x when req_x, else 0.
  - If req_x drops without last, stay in OWNx. Bubble cycles do not count as beats.
  - Each accepted beat increments the beat counter.
  - Exit to IDLE and set last_winner=x when an accepted beat has last_x=1.
  - Also exit when MAX_BURST is nonzero and the counter reaches MAX_BURST with that beat (forced release).
  - On exit, the counter clears. The next cycle's arbitration uses the updated last_winner.
- Address/enable when nothing is granted: mem_ena=0, mem_addra=0.
- Read return:
  - A tag shift register of depth RD_LAT records {valid, id} on every granted cycle.
  - rvalid_id=1 exactly RD_LAT cycles after the gnt_id cycle.
  - rvalid0 and rvalid1 are never both high.
  - rdata is a combinational pass-through of mem_douta.
- Throughput: one beat per cycle, including back-to-back bursts from alternating requesters (no dead cycle at handover).
- Requester obligations: addr and last are sampled only in a gnt cycle. A requester may change them freely otherwise.
- Reset mid-burst or mid-read: ownership is released and in-flight tags are discarded. No rvalid fires for reads issued before reset.
- Inputs with req=0 are ignored, including last and addr.

Test Plan:
- Single beat: reset, then req0=1, addr0=0x10, last0=1 for one cycle. Required: gnt0=1 that cycle, mem_addra=0x10, mem_ena=1; rvalid0=1 exactly RD_LAT=1 cycle later with rdata=mem[0x10]; owner stays 00.
- Burst lock: requester 0 issues a burst on addresses 0x00 to 0x07 (last0 on 0x07) while req1 is held high from the second beat. Required: gnt1=0 for all 8 beats and owner=01. In the cycle after the last beat, gnt1=1 and owner moves to 10 (or stays 00 if last1=1).
- Round robin: after reset, req0 and req1 both high with last=1 every cycle for 6 cycles. Required: grants alternate 0,1,0,1,0,1, and rvalid alternates one cycle later.
- Forced release: MAX_BURST=4; requester 1 bursts 10 beats with last1 never set, req0 held high. Required: requester 1 receives 4 grants, then requester 0 is granted on the next cycle; requester 1 regains the memory afterwards.
- Bubbles: owner 0 drops req0 for 3 cycles mid-burst with req1 high. Required: no grants to either requester, mem_ena=0, owner=01, and the beat counter is unchanged.
- Reset mid-read: RD_LAT=3; assert reset one cycle after gnt0. Required: all outputs go to reset values immediately, and no rvalid0 pulse follows.
